// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART transmitter: state encodings, line levels, parity helper.
// FIFO_UART_TX_PARITY_EN adds the PARITY state (even parity after the data bits).
package fifo_uart_tx_pkg;

  localparam int CLKS_PER_BIT_DEF = 208;
  localparam int DATA_W           = 8;

  localparam logic UART_MARK  = 1'b1;
  localparam logic UART_SPACE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes o_tick on the last clock of a bit.
module uart_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  assign o_tick = i_en && (cnt_r == CNT_LAST);

  // next count: clear wins, otherwise wrap at the bit boundary
  always_comb begin
    cnt_s = cnt_r;
    if (i_clr) begin
      cnt_s = '0;
    end else if (i_en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s = '0;
      end else begin
        cnt_s = cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // counter register
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the capture FIFO and sends each as an 8N1 UART frame, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_WIDTH   = DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_res_n,
  output logic                  o_fifo_ren,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_uart_tx,
  output logic                  o_busy
);

  tx_state_e             state_r, state_s;
  logic                  tx_r, tx_s;
  logic                  ren_r, ren_s;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [2:0]            bit_r, bit_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_r, par_s;
`endif
  logic                  tick_s;
  logic                  clr_s;
  logic                  en_s;

  // counter restarts at frame start so START lasts exactly one bit time
  assign clr_s = (state_r == ST_LOAD);
  assign en_s  = (state_r != ST_IDLE) && (state_r != ST_FETCH) && (state_r != ST_LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_res_n(i_res_n),
    .i_clr  (clr_s),
    .i_en   (en_s),
    .o_tick (tick_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_s = state_r;
    tx_s    = tx_r;
    ren_s   = 1'b0;
    shift_s = shift_r;
    bit_s   = bit_r;
`ifdef FIFO_UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        tx_s = UART_MARK;
        if (!i_fifo_empty) begin
          ren_s   = 1'b1;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        shift_s = i_fifo_data;
        bit_s   = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_s   = even_parity(i_fifo_data);
`endif
        tx_s    = UART_SPACE;
        state_s = ST_START;
      end
      ST_START: begin
        if (tick_s) begin
          tx_s    = shift_r[0];
          shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          bit_s = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_s    = par_r;
            state_s = ST_PARITY;
`else
            tx_s    = UART_MARK;
            state_s = ST_STOP;
`endif
          end else begin
            tx_s    = shift_r[0];
            shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          tx_s    = UART_MARK;
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          tx_s    = UART_MARK;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        tx_s    = UART_MARK;
        state_s = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs; reset forces the line to mark at once
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_r <= ST_IDLE;
      tx_r    <= UART_MARK;
      ren_r   <= 1'b0;
      busy_r  <= 1'b0;
      shift_r <= '0;
      bit_r   <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      tx_r    <= tx_s;
      ren_r   <= ren_s;
      busy_r  <= (state_s != ST_IDLE);
      shift_r <= shift_s;
      bit_r   <= bit_s;
`ifdef FIFO_UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign o_uart_tx  = tx_r;
  assign o_fifo_ren = ren_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: table of bytes with hand-written line frames, plus reset and burst sequences.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int N1 = 4;
  localparam int N2 = 2;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit0 = start, bits 8:1 = data LSB first, bit9 = stop
    logic       par;
  } vec_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, rst2_n;
  logic       ren1, empty1, tx1, busy1;
  logic       ren2, empty2, tx2, busy2;
  logic [7:0] data1, data2;

  logic [7:0] mem1 [0:31];
  logic [7:0] mem2 [0:31];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  int ren_cnt1 = 0, busy_cnt1 = 0, ren_cnt2 = 0;

  int vecs = 0, errs = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(N1)) u_dut1 (
    .i_clk(clk), .i_res_n(rst1_n), .o_fifo_ren(ren1), .i_fifo_data(data1),
    .i_fifo_empty(empty1), .o_uart_tx(tx1), .o_busy(busy1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(N2)) u_dut2 (
    .i_clk(clk), .i_res_n(rst2_n), .o_fifo_ren(ren2), .i_fifo_data(data2),
    .i_fifo_empty(empty2), .o_uart_tx(tx2), .o_busy(busy2)
  );

  // FIFO models with registered read data, plus strobe/busy counters
  assign empty1 = (wr1 == rd1);
  assign empty2 = (wr2 == rd2);

  always @(posedge clk) begin
    if (ren1 && (wr1 != rd1)) begin
      data1 <= mem1[rd1[4:0]];
      rd1   <= rd1 + 1;
    end
    if (ren1) ren_cnt1 <= ren_cnt1 + 1;
    if (busy1) busy_cnt1 <= busy_cnt1 + 1;
  end

  always @(posedge clk) begin
    if (ren2 && (wr2 != rd2)) begin
      data2 <= mem2[rd2[4:0]];
      rd2   <= rd2 + 1;
    end
    if (ren2) ren_cnt2 <= ren_cnt2 + 1;
  end

  // UART decoder for the fast instance, sampling mid-bit
  logic [7:0] dec_b;
  logic [7:0] rx2 [0:31];
  int rx_cnt2 = 0, frame_err2 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst2_n === 1'b1 && tx2 === 1'b0) begin
        repeat (N2 / 2) @(negedge clk);
        if (tx2 !== 1'b0) frame_err2++;
        for (int k = 0; k < 8; k++) begin
          repeat (N2) @(negedge clk);
          dec_b[k] = tx2;
        end
`ifdef FIFO_UART_TX_PARITY_EN
        repeat (N2) @(negedge clk);
        if (tx2 !== ^dec_b) frame_err2++;
`endif
        repeat (N2) @(negedge clk);
        if (tx2 !== 1'b1) frame_err2++;
        rx2[rx_cnt2[4:0]] = dec_b;
        rx_cnt2++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1[4:0]] = b;
    wr1 = wr1 + 1;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wr2[4:0]] = b;
    wr2 = wr2 + 1;
  endtask

  // counts mark cycles (including the current one) until the start bit appears
  task automatic wait_start1(output int n);
    n = 0;
    while (tx1 === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // entered on the first start-bit cycle; leaves on the first cycle after stop
  task automatic check_frame1(input logic [9:0] fr, input logic p, input string tag);
    logic [NBITS-1:0] exp_bits;
    logic             seen;
`ifdef FIFO_UART_TX_PARITY_EN
    exp_bits = {fr[9], p, fr[8:0]};
`else
    exp_bits = fr;
    if (p === 1'bx) exp_bits = fr;
`endif
    for (int b = 0; b < NBITS; b++) begin
      seen = exp_bits[b];
      for (int c = 0; c < N1; c++) begin
        if (tx1 !== exp_bits[b]) seen = tx1;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(seen), 32'(exp_bits[b]));
    end
  endtask

  vec_t tbl [8];
  int   n, r0, b0, bad, t;
  logic [7:0] exp2 [0:15];

  initial begin
    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'h55, 10'b1010101010, 1'b0};
    tbl[4] = '{8'h01, 10'b1000000010, 1'b1};
    tbl[5] = '{8'h80, 10'b1100000000, 1'b1};
    tbl[6] = '{8'h7E, 10'b1011111100, 1'b0};
    tbl[7] = '{8'h13, 10'b1000100110, 1'b1};

    rst1_n = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx1), 32'd1);
    chk("rst_ren", 32'(ren1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    rst1_n = 1'b1;
    rst2_n = 1'b1;

    // long idle with an empty FIFO
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || ren1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    chk("idle_100", 32'(bad), 32'd0);

    // one byte at a time from the table
    for (int i = 0; i < 8; i++) begin
      r0 = ren_cnt1;
      b0 = busy_cnt1;
      push1(tbl[i].data);
      wait_start1(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd3);
      check_frame1(tbl[i].frame, tbl[i].par, $sformatf("v%0d", i));
      chk($sformatf("v%0d_ren", i), 32'(ren_cnt1 - r0), 32'd1);
      chk($sformatf("v%0d_busy", i), 32'(busy_cnt1 - b0), 32'(2 + NBITS * N1));
    end

    // three queued bytes go out with a 3-clock mark gap
    r0 = ren_cnt1;
    push1(tbl[1].data);
    push1(tbl[2].data);
    push1(tbl[3].data);
    for (int k = 1; k < 4; k++) begin
      wait_start1(n);
      chk($sformatf("burst%0d_gap", k), 32'(n), 32'd3);
      check_frame1(tbl[k].frame, tbl[k].par, $sformatf("burst%0d", k));
    end
    chk("burst_ren", 32'(ren_cnt1 - r0), 32'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("burst_idle", 32'(bad), 32'd0);

    // reset during data bit 3 of 0x3C, then a clean 0x81
    r0 = ren_cnt1;
    push1(8'h3C);
    wait_start1(n);
    chk("rst_case_latency", 32'(n), 32'd3);
    repeat (4 * N1 + 1) @(negedge clk);
    chk("pre_reset_busy", 32'(busy1), 32'd1);
    rst1_n = 1'b0;
    #1;
    chk("async_tx", 32'(tx1), 32'd1);
    chk("async_busy", 32'(busy1), 32'd0);
    chk("async_ren", 32'(ren1), 32'd0);
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || ren1 !== 1'b0) bad++;
    end
    chk("post_reset_quiet", 32'(bad), 32'd0);
    chk("post_reset_ren", 32'(ren_cnt1 - r0), 32'd1);
    push1(8'h81);
    wait_start1(n);
    chk("after_rst_latency", 32'(n), 32'd3);
    check_frame1(10'b1100000010, 1'b0, "after_rst");
    chk("after_rst_ren", 32'(ren_cnt1 - r0), 32'd2);

    // fast instance: 16 random bytes back to back
    r0 = ren_cnt2;
    for (int k = 0; k < 16; k++) begin
      exp2[k] = 8'($urandom_range(0, 255));
      push2(exp2[k]);
    end
    t = 0;
    while (rx_cnt2 < 16 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rx_count", 32'(rx_cnt2), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rx%0d", k), 32'(rx2[k]), 32'(exp2[k]));
    end
    repeat (10) @(negedge clk);
    chk("rx_ren", 32'(ren_cnt2 - r0), 32'd16);
    chk("rx_frame_err", 32'(frame_err2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
